// File: rtl/llc_input_arbiter_pkg.sv
// Shared types for the LLC input arbiter: FSM states, grant kinds and a wrap helper.
package llc_input_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_SET,
    ST_STALL
  } arb_state_e;

  typedef enum logic [1:0] {
    GK_NONE,
    GK_CH,
    GK_SWEEP,
    GK_REPLAY
  } grant_kind_e;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/llc_rr_picker.sv
// Combinational picker: first requesting channel at or after ptr_i (ptr_i=0 gives fixed priority).
module llc_rr_picker #(
  parameter int NUM_CH = 4,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic              valid_o,
  output logic [IDX_W-1:0]  idx_o
);

  int               cand;
  logic [IDX_W-1:0] candIdx;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    candIdx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand    = (int'(ptr_i) + i) % NUM_CH;
      candIdx = IDX_W'(cand);
      if (!valid_o && req_i[candIdx]) begin
        valid_o = 1'b1;
        idx_o   = candIdx;
      end
    end
  end

endmodule

// File: rtl/llc_input_arbiter.sv
// LLC front-end arbiter: one grant per 4-cycle decode pass among channels, set sweep
// and stalled-request replay, with registered grant outputs.
module llc_input_arbiter
  import llc_input_arbiter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int LINE_ADDR_W = 26,
  parameter int SET_BITS    = 9,
  parameter int ARB_MODE    = 0,
  parameter int STALL_CH    = 2,
  parameter int RSP_CH      = 1,
  localparam int IDX_W      = $clog2(NUM_CH),
  localparam int TAG_W      = LINE_ADDR_W - SET_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          decode_en,
  input  logic [NUM_CH-1:0]             ch_valid,
  input  logic [NUM_CH*LINE_ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH-1:0]             ch_block,
  input  logic                          sweep_start,
  input  logic                          stall_capture,
  output logic [NUM_CH-1:0]             ch_ready,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_ch,
  output logic                          grant_sweep,
  output logic                          grant_replay,
  output logic [TAG_W-1:0]              tag,
  output logic [SET_BITS-1:0]           set,
  output logic                          req_stall,
  output logic                          sweep_active,
  output logic                          sweep_done
);

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [SET_BITS-1:0] set;
  } stall_buf_t;

  arb_state_e          state_q;
  grant_kind_e         kind_q, kind_d;
  logic [NUM_CH-1:0]   valid_q, block_q, elig;
  logic [NUM_CH-1:0]   ch_ready_q;
  logic                grant_valid_q, grant_sweep_q, grant_replay_q;
  logic [IDX_W-1:0]    grant_ch_q, ptr_q, pick_ptr, pick_idx;
  logic                pick_valid;
  logic [TAG_W-1:0]    tag_q, tag_d, last_tag_q;
  logic [SET_BITS-1:0] set_q, set_d, last_set_q, sweep_cnt_q;
  logic                req_stall_q, sweep_active_q, sweep_done_q;
  logic [LINE_ADDR_W-1:0] sel_addr;
  stall_buf_t          stall_buf_q;
  logic                rsp_match;

  // STALL_CH sits out while its request is parked; a sweep owns every pass.
  always_comb begin
    elig = valid_q & ~block_q;
    if (req_stall_q) elig[STALL_CH] = 1'b0;
    if (sweep_active_q) elig = '0;
  end

  assign pick_ptr = (ARB_MODE == 1) ? ptr_q : '0;

  llc_rr_picker #(.NUM_CH(NUM_CH)) u_picker (
    .req_i   (elig),
    .ptr_i   (pick_ptr),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_idx == IDX_W'(i)) sel_addr = ch_addr[i*LINE_ADDR_W +: LINE_ADDR_W];
    end
  end

  always_comb begin
    kind_d = GK_NONE;
    tag_d  = tag_q;
    set_d  = set_q;
    if (sweep_active_q) begin
      kind_d = GK_SWEEP;
      tag_d  = '0;
      set_d  = sweep_cnt_q;
    end else if (stall_buf_q.valid && !req_stall_q) begin
      kind_d = GK_REPLAY;
      tag_d  = stall_buf_q.tag;
      set_d  = stall_buf_q.set;
    end else if (pick_valid) begin
      kind_d = GK_CH;
      tag_d  = sel_addr[LINE_ADDR_W-1:SET_BITS];
      set_d  = sel_addr[SET_BITS-1:0];
    end
  end

  assign rsp_match = (kind_q == GK_CH) && (grant_ch_q == IDX_W'(RSP_CH)) &&
                     stall_buf_q.valid && (stall_buf_q.tag == tag_q) &&
                     (stall_buf_q.set == set_q);

  // Pass sequencer; capture is applied last so it overrides a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      kind_q         <= GK_NONE;
      valid_q        <= '0;
      block_q        <= '0;
      ch_ready_q     <= '0;
      grant_valid_q  <= 1'b0;
      grant_ch_q     <= '0;
      grant_sweep_q  <= 1'b0;
      grant_replay_q <= 1'b0;
      tag_q          <= '0;
      set_q          <= '0;
      last_tag_q     <= '0;
      last_set_q     <= '0;
      ptr_q          <= '0;
      sweep_cnt_q    <= '0;
      sweep_active_q <= 1'b0;
      sweep_done_q   <= 1'b0;
      req_stall_q    <= 1'b0;
      stall_buf_q    <= '0;
    end else begin
      valid_q       <= ch_valid;
      block_q       <= ch_block;
      ch_ready_q    <= '0;
      grant_valid_q <= 1'b0;
      sweep_done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (decode_en) state_q <= ST_DECODE;
        end
        ST_DECODE: begin
          state_q <= ST_SET;
          kind_q  <= kind_d;
          if (kind_d != GK_NONE) begin
            grant_valid_q  <= 1'b1;
            tag_q          <= tag_d;
            set_q          <= set_d;
            grant_sweep_q  <= (kind_d == GK_SWEEP);
            grant_replay_q <= (kind_d == GK_REPLAY);
            if (kind_d == GK_CH) begin
              grant_ch_q           <= pick_idx;
              ch_ready_q[pick_idx] <= 1'b1;
            end
            if ((kind_d == GK_REPLAY) ||
                ((kind_d == GK_CH) && (pick_idx == IDX_W'(STALL_CH)))) begin
              last_tag_q <= tag_d;
              last_set_q <= set_d;
            end
          end
        end
        ST_SET: begin
          state_q <= ST_STALL;
          if ((kind_q == GK_SWEEP) && (&sweep_cnt_q)) sweep_done_q <= 1'b1;
        end
        ST_STALL: begin
          state_q <= ST_IDLE;
          if ((ARB_MODE == 1) && (kind_q == GK_CH))
            ptr_q <= IDX_W'(wrap_inc(int'(grant_ch_q), NUM_CH));
          if (kind_q == GK_SWEEP) begin
            sweep_cnt_q <= sweep_cnt_q + 1'b1;
            if (&sweep_cnt_q) sweep_active_q <= 1'b0;
          end
          if (kind_q == GK_REPLAY) stall_buf_q.valid <= 1'b0;
          if (rsp_match) req_stall_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (sweep_start && !sweep_active_q) begin
        sweep_cnt_q    <= '0;
        sweep_active_q <= 1'b1;
      end
      if (stall_capture) begin
        stall_buf_q <= '{valid: 1'b1, tag: last_tag_q, set: last_set_q};
        req_stall_q <= 1'b1;
      end
    end
  end

  assign ch_ready     = ch_ready_q;
  assign grant_valid  = grant_valid_q;
  assign grant_ch     = grant_ch_q;
  assign grant_sweep  = grant_sweep_q;
  assign grant_replay = grant_replay_q;
  assign tag          = tag_q;
  assign set          = set_q;
  assign req_stall    = req_stall_q;
  assign sweep_active = sweep_active_q;
  assign sweep_done   = sweep_done_q;

endmodule

// File: tb/tb_llc_input_arbiter.sv
// Directed bench: fixed-priority instance (SET_BITS=9) and round-robin instance (SET_BITS=2).
module tb_llc_input_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   chValid, chBlock;
  logic [103:0] chAddr;
  logic [25:0]  addrTab [4];
  int           testCount = 0;
  int           failCount = 0;

  logic        fDecode, fSweepStart, fCapture;
  logic [3:0]  fReady;
  logic        fGrantValid, fGrantSweep, fGrantReplay, fReqStall, fSweepActive, fSweepDone;
  logic [1:0]  fGrantCh;
  logic [16:0] fTag;
  logic [8:0]  fSet;

  logic        rDecode, rSweepStart, rCapture;
  logic [3:0]  rReady;
  logic        rGrantValid, rGrantSweep, rGrantReplay, rReqStall, rSweepActive, rSweepDone;
  logic [1:0]  rGrantCh;
  logic [23:0] rTag;
  logic [1:0]  rSet;

  always #5 clk = ~clk;

  llc_input_arbiter #(.ARB_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .decode_en(fDecode), .ch_valid(chValid), .ch_addr(chAddr),
    .ch_block(chBlock), .sweep_start(fSweepStart), .stall_capture(fCapture),
    .ch_ready(fReady), .grant_valid(fGrantValid), .grant_ch(fGrantCh),
    .grant_sweep(fGrantSweep), .grant_replay(fGrantReplay), .tag(fTag), .set(fSet),
    .req_stall(fReqStall), .sweep_active(fSweepActive), .sweep_done(fSweepDone)
  );

  llc_input_arbiter #(.ARB_MODE(1), .SET_BITS(2)) u_rr (
    .clk(clk), .rst(rst), .decode_en(rDecode), .ch_valid(chValid), .ch_addr(chAddr),
    .ch_block(chBlock), .sweep_start(rSweepStart), .stall_capture(rCapture),
    .ch_ready(rReady), .grant_valid(rGrantValid), .grant_ch(rGrantCh),
    .grant_sweep(rGrantSweep), .grant_replay(rGrantReplay), .tag(rTag), .set(rSet),
    .req_stall(rReqStall), .sweep_active(rSweepActive), .sweep_done(rSweepDone)
  );

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] block);
    chValid = valid;
    chBlock = block;
    chAddr  = {addrTab[3], addrTab[2], addrTab[1], addrTab[0]};
  endtask

  // Returns at the negedge inside the SET state of the pass.
  task automatic startPass(input bit useRr);
    @(posedge clk); #1;
    if (useRr) rDecode = 1'b1; else fDecode = 1'b1;
    @(posedge clk); #1;
    rDecode = 1'b0;
    fDecode = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic pulseCtrl(input bit useRr, input bit isSweep);
    @(posedge clk); #1;
    if (useRr) begin
      if (isSweep) rSweepStart = 1'b1; else rCapture = 1'b1;
    end else begin
      if (isSweep) fSweepStart = 1'b1; else fCapture = 1'b1;
    end
    @(posedge clk); #1;
    {rSweepStart, rCapture, fSweepStart, fCapture} = '0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    {fDecode, fSweepStart, fCapture, rDecode, rSweepStart, rCapture} = '0;
    addrTab[0] = 26'h10;
    addrTab[1] = 26'h4A5;
    addrTab[2] = 26'h123;
    addrTab[3] = 26'h200;
    applyStimulus(4'b0000, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", fReady, 0);
    checkOutput("rst_gvalid", fGrantValid, 0);
    checkOutput("rst_gch", fGrantCh, 0);
    checkOutput("rst_set", fSet, 0);
    checkOutput("rst_reqstall", fReqStall, 0);
    checkOutput("rst_sweepact", rSweepActive, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Fixed priority: lowest eligible index wins
    applyStimulus(4'b0110, 4'b0000);
    startPass(0);
    checkOutput("fix_ready", fReady, 4'b0010);
    checkOutput("fix_gvalid", fGrantValid, 1);
    checkOutput("fix_gch", fGrantCh, 1);
    checkOutput("fix_tag", fTag, 2);
    checkOutput("fix_set", fSet, 9'h0A5);
    nextCycle();
    checkOutput("fix_ready_stall", fReady, 0);
    checkOutput("fix_gvalid_stall", fGrantValid, 0);
    checkOutput("fix_gch_held", fGrantCh, 1);
    nextCycle();

    // Round robin over all four channels, two full rotations
    applyStimulus(4'b1111, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      startPass(1);
      checkOutput($sformatf("rr_gch_%0d", k), rGrantCh, k % 4);
      checkOutput($sformatf("rr_ready_%0d", k), rReady, 1 << (k % 4));
      checkOutput($sformatf("rr_set_%0d", k), rSet, addrTab[k % 4] & 26'h3);
      checkOutput($sformatf("rr_tag_%0d", k), rTag, addrTab[k % 4] >> 2);
      nextCycle();
      nextCycle();
    end

    // Set sweep over 4 sets masks every channel
    pulseCtrl(1, 1);
    checkOutput("sw_active", rSweepActive, 1);
    for (int k = 0; k < 4; k++) begin
      startPass(1);
      checkOutput($sformatf("sw_gvalid_%0d", k), rGrantValid, 1);
      checkOutput($sformatf("sw_ready_%0d", k), rReady, 0);
      checkOutput($sformatf("sw_flag_%0d", k), rGrantSweep, 1);
      checkOutput($sformatf("sw_set_%0d", k), rSet, k);
      checkOutput($sformatf("sw_tag_%0d", k), rTag, 0);
      nextCycle();
      checkOutput($sformatf("sw_done_%0d", k), rSweepDone, (k == 3) ? 1 : 0);
      nextCycle();
    end
    checkOutput("sw_inactive", rSweepActive, 0);
    checkOutput("sw_done_clear", rSweepDone, 0);
    startPass(1);
    checkOutput("sw_after_gch", rGrantCh, 0);
    checkOutput("sw_after_ready", rReady, 4'b0001);
    checkOutput("sw_after_flag", rGrantSweep, 0);
    nextCycle();
    nextCycle();

    // Stall capture, response match and replay
    applyStimulus(4'b0100, 4'b0000);
    startPass(0);
    checkOutput("st_ch2_ready", fReady, 4'b0100);
    checkOutput("st_ch2_set", fSet, 9'h123);
    nextCycle();
    nextCycle();
    pulseCtrl(0, 0);
    checkOutput("st_reqstall", fReqStall, 1);
    startPass(0);
    checkOutput("st_masked_gvalid", fGrantValid, 0);
    checkOutput("st_masked_ready", fReady, 0);
    nextCycle();
    nextCycle();
    addrTab[1] = 26'h123;
    applyStimulus(4'b0010, 4'b0000);
    startPass(0);
    checkOutput("st_rsp_ready", fReady, 4'b0010);
    nextCycle();
    checkOutput("st_rsp_stall_still", fReqStall, 1);
    nextCycle();
    checkOutput("st_rsp_cleared", fReqStall, 0);
    applyStimulus(4'b0110, 4'b0000);
    startPass(0);
    checkOutput("rp_gvalid", fGrantValid, 1);
    checkOutput("rp_flag", fGrantReplay, 1);
    checkOutput("rp_ready", fReady, 0);
    checkOutput("rp_set", fSet, 9'h123);
    checkOutput("rp_tag", fTag, 0);
    nextCycle();
    nextCycle();
    applyStimulus(4'b0100, 4'b0000);
    startPass(0);
    checkOutput("rp_after_ready", fReady, 4'b0100);
    checkOutput("rp_after_flag", fGrantReplay, 0);
    nextCycle();
    nextCycle();

    // External block leaves no eligible source
    applyStimulus(4'b0001, 4'b0001);
    startPass(0);
    checkOutput("blk_gvalid", fGrantValid, 0);
    checkOutput("blk_ready", fReady, 0);
    checkOutput("blk_gch_held", fGrantCh, 2);
    checkOutput("blk_set_held", fSet, 9'h123);
    nextCycle();
    nextCycle();

    // Reset asserted during SET
    applyStimulus(4'b0001, 4'b0000);
    startPass(0);
    rst = 1'b0;
    #1;
    checkOutput("rstmid_ready", fReady, 0);
    checkOutput("rstmid_gvalid", fGrantValid, 0);
    checkOutput("rstmid_gch", fGrantCh, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    startPass(0);
    checkOutput("rstmid_next_ready", fReady, 4'b0001);
    checkOutput("rstmid_next_set", fSet, 9'h010);
    nextCycle();
    nextCycle();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
